// File: rtl/error_pattern_generator.sv
// Stream source that emits a deterministic payload sequence over valid/ready and periodically
// substitutes a reserved error word. The payload itself never takes the reserved value.
module error_pattern_generator #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] ERR_PATTERN = WIDTH'(8'b10101010),
    parameter int unsigned      COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] word_count,
    input  logic [COUNT_W-1:0] inject_interval,
    input  logic [WIDTH-1:0]   seed,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               inject_flag,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] sent_count,
    output logic [COUNT_W-1:0] injected_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] interval_q;
    logic [COUNT_W-1:0] inj_cnt;      // position of the presented word within its interval; 1 = injected slot
    logic [WIDTH-1:0]   payload;      // next non-injected payload value

    logic               xfer_c;
    logic [WIDTH-1:0]   seed_adj_c;
    logic [WIDTH-1:0]   payload_adv_c;
    logic [COUNT_W-1:0] inj_cnt_adv_c;
    logic               inject_next_c;

    function automatic logic [WIDTH-1:0] skip_err(input logic [WIDTH-1:0] v);
        return (v == ERR_PATTERN) ? v + WIDTH'(1) : v;
    endfunction

    // Next-word computation after an accepted transfer
    always_comb begin
        xfer_c        = (state == SEND) && data_valid && data_ready;
        seed_adj_c    = skip_err(seed);
        payload_adv_c = inject_flag ? payload : skip_err(payload + WIDTH'(1));
        if (interval_q == '0) begin
            inj_cnt_adv_c = '0;
        end else if (inj_cnt == COUNT_W'(1)) begin
            inj_cnt_adv_c = interval_q;
        end else begin
            inj_cnt_adv_c = inj_cnt - COUNT_W'(1);
        end
        inject_next_c = (interval_q != '0) && (inj_cnt_adv_c == COUNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            remaining      <= '0;
            interval_q     <= '0;
            inj_cnt        <= '0;
            payload        <= '0;
            data_out       <= '0;
            data_valid     <= 1'b0;
            inject_flag    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sent_count     <= '0;
            injected_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sent_count     <= '0;
                        injected_count <= '0;
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state       <= SEND;
                            remaining   <= word_count;
                            interval_q  <= inject_interval;
                            inj_cnt     <= inject_interval;
                            payload     <= seed_adj_c;
                            busy        <= 1'b1;
                            data_valid  <= 1'b1;
                            inject_flag <= (inject_interval == COUNT_W'(1));
                            data_out    <= (inject_interval == COUNT_W'(1)) ? ERR_PATTERN : seed_adj_c;
                        end
                    end
                end
                SEND: begin
                    if (xfer_c) begin
                        sent_count <= sent_count + COUNT_W'(1);
                        if (inject_flag) begin
                            injected_count <= injected_count + COUNT_W'(1);
                        end
                        remaining <= remaining - COUNT_W'(1);
                        payload   <= payload_adv_c;
                        inj_cnt   <= inj_cnt_adv_c;
                        if (remaining == COUNT_W'(1)) begin
                            state       <= DONE;
                            data_valid  <= 1'b0;
                            data_out    <= '0;
                            inject_flag <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            data_out    <= inject_next_c ? ERR_PATTERN : payload_adv_c;
                            inject_flag <= inject_next_c;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/error_pattern_generator.md
# error_pattern_generator

Stimulus source for the data path guarded by the error checker. On command it emits a bounded stream of deterministic payload words over a valid/ready handshake. At a programmed interval it injects the reserved error pattern in place of a payload word, and it reports how many words and injections were actually delivered. The checker downstream must flag exactly the injected words, so the normal payload sequence never produces the error pattern.

## Interface
- WIDTH, 8, data word width
- ERR_PATTERN, 8'b10101010 (WIDTH bits), reserved word that the checker treats as an error
- COUNT_W, 16, width of the length, interval and statistics counters
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high; clears all state and outputs
- start  input  1  one-cycle command pulse; sampled only in IDLE
- word_count  input  COUNT_W  number of words to send; latched on start
- inject_interval  input  COUNT_W  every Nth word is ERR_PATTERN; 0 disables injection; latched on start
- seed  input  WIDTH  first payload value; latched on start
- data_out  output  WIDTH  current word
- data_valid  output  1  data_out holds a word to transfer
- data_ready  input  1  sink accepts; a transfer occurs when data_valid && data_ready at a rising edge
- inject_flag  output  1  high while the presented word is an injected ERR_PATTERN
- busy  output  1  high in SEND and DONE
- done  output  1  one-cycle completion pulse
- sent_count  output  COUNT_W  transfers completed since last start
- injected_count  output  COUNT_W  injected transfers completed since last start

## Operation
- All outputs are registered. Reset value is 0 for every output, and the state is IDLE.
- States: IDLE, SEND, DONE.
- **IDLE:**
  - start with word_count == 0: done pulses for one cycle, the counters clear, and the state stays IDLE.
  - start with word_count != 0: latch word_count, inject_interval and seed, clear both counters, and go to SEND.
  - If the latched seed == ERR_PATTERN, the first payload value is seed+1.
- **Payload rule:**
  - The payload register advances by +1, modulo 2^WIDTH.
  - Any value equal to ERR_PATTERN is skipped by adding a further +1.
  - Payload never equals ERR_PATTERN.
- **Injection rule:**
  - The word with 1-based index k is injected when inject_interval != 0 and k mod inject_interval == 0. Implement this with a down-counter reloaded from the interval, not a divider.
  - An injected word presents ERR_PATTERN with inject_flag=1.
  - The payload register does not advance on an injected transfer.
- **SEND:**
  - data_valid=1.
  - On each transfer:
    - sent_count increments.
    - injected_count increments if the word was injected.
    - The remaining count decrements.
    - The next word is presented in the following cycle.
  - On the transfer of the last word: data_valid falls, and the state goes to DONE.
- **DONE:** done=1 for exactly one cycle, busy=1, data_valid=0; then the state goes to IDLE.
- **Backpressure:** while data_valid=1 and data_ready=0, data_out, inject_flag and both counters hold unchanged.
- **start outside IDLE:** ignored, with no effect on the stream or the latched parameters.
- **Outside SEND:** data_out=0 and inject_flag=0. sent_count and injected_count hold their final values until the next start or reset.
- **Counters:**
  - Counters cannot overflow, because a run is bounded by word_count ≤ 2^COUNT_W−1.
  - inject_interval == 1 injects every word.
  - inject_interval > word_count injects nothing.
- **Reset mid-run:** on the next edge the block is IDLE with all outputs 0. The interrupted stream is abandoned and is not resumed.

## Timing
- start sampled at edge t: first word valid from t+1.
- Throughput: one word per cycle while data_ready=1.
- Completion: last transfer at edge e gives done=1 during the cycle after e (DONE state). IDLE follows at e+2.
- Earliest next start: sampled at e+2, first word at e+3.
- Zero-length start at edge t: done=1 during t+1, busy stays 0.
- reset has priority over start and over a concurrent transfer at the same edge.

## Test plan
- **Reset:** assert reset for 2 cycles with start=1 and data_ready=1 → every output 0 and no transfer; after release with start=0, everything stays idle.
- **Basic stream:**
  - Stimulus: seed=0x10, word_count=4, inject_interval=0, data_ready=1.
  - Required: data_out 0x10, 0x11, 0x12, 0x13 in cycles t+1..t+4; done during t+5; sent_count=4; injected_count=0.
- **Pattern skip and wrap:** seed=0xA8, word_count=4 → data_out A8, A9, AB, AC. Separately, seed=0xFE, word_count=3 → FE, FF, 00.
- **Injection:**
  - Stimulus: seed=0x00, word_count=7, inject_interval=3.
  - Required: data_out 00, 01, AA, 02, 03, AA, 04; inject_flag on words 3 and 6 only; injected_count=2; sent_count=7.
- **Backpressure:** during the basic stream, hold data_ready=0 for 3 cycles while word 2 (0x11) is presented → 0x11 is held stable, valid stays high and sent_count stays 1; the stream resumes 0x11, 0x12, 0x13 with no drops or duplicates.
- **Robustness:**
  - A start pulse mid-stream is ignored.
  - reset asserted after word 2 → the next cycle is IDLE with all outputs 0.
  - A zero-length start → a single done pulse with no data_valid.
